lvds_prbs_chk: RTL
==================

Name: lvds_prbs_chk

Overview:
- Per-lane PRBS7 checker on the receive side, directly downstream of lvds_phy_rx, in the CLKDIV_I domain.
- Consumes the deserialised lane words and the per-lane BIT_ALIGN/BYTE_ALIGN flags.
- Self-synchronises to a PRBS7 (x^7+x^6+1) stream, declares per-lane lock, and counts errored words for link bring-up and BER soak testing.
- Outputs feed the ILA/VIO in the LVDS test top.

Parameters:
- C_LANE_NUM, 2, number of LVDS lanes.
- C_DATA_WIDTH_PER_LANE, 8, bits per lane word. Legal range 7..16.
- C_LOCK_CNT, 64, consecutive good words required to enter LOCKED. Minimum 2.
- C_UNLOCK_CNT, 4, consecutive errored words in LOCKED that drop lock. Minimum 1.
- C_ERR_CNT_W, 16, width of each per-lane saturating error counter.

Ports:
- CLKDIV_I  in  1  word clock; all logic on its rising edge.
- CLKDIV_RST_I  in  1  synchronous, active-high reset.
- LVDS_DATA_I  in  C_LANE_NUM*C_DATA_WIDTH_PER_LANE  lane words; lane i at [i*W +: W]; bit W-1 is earliest on the wire.
- DATA_VALID_I  in  1  word strobe, common to all lanes; tie high for continuous data.
- BIT_ALIGN_I  in  C_LANE_NUM  per-lane bit-align done, from the rx PHY.
- BYTE_ALIGN_I  in  C_LANE_NUM  per-lane byte-align done, from the rx PHY.
- CLR_I  in  1  synchronous clear of error counters only; FSM state is not affected.
- LOCK_O  out  C_LANE_NUM  per-lane PRBS lock.
- ERR_FLAG_O  out  C_LANE_NUM  one-cycle pulse per errored word while LOCKED.
- ERR_CNT_O  out  C_LANE_NUM*C_ERR_CNT_W  per-lane saturating errored-word count.

Behaviour:
- Interface (already decided): one clock, CLKDIV_I. Reset CLKDIV_RST_I is synchronous and active-high.
- Reset values: LOCK_O=0, ERR_FLAG_O=0, ERR_CNT_O=0, all FSMs in WAIT_ALIGN, prime flags clear.
- Lanes are fully independent; sharing is limited to DATA_VALID_I and CLR_I.
- Pipeline:
  - Stage 1 registers the input word when DATA_VALID_I=1.
  - The compare result is registered in stage 2.
  - ERR_FLAG_O and counter updates appear 2 cycles after the word is presented.
  - LOCK_O changes in the same cycle as the deciding compare result is registered.
- Prediction, with sequence indices s[t] in time order:
  - Expected bit is s[t] = s[t-6] ^ s[t-7].
  - Bits come from the previous valid word and the earlier bits of the current received word.
  - Word is good iff all W bits match AND the word is non-zero.
  - The all-zero word always counts as an error (PRBS lock-up guard).
- Prime: the first valid word after entering WAIT_ALIGN→HUNT only loads the previous-word register and is never checked.
- Per-lane FSM:
  - WAIT_ALIGN:
    - Hold here while BIT_ALIGN_I & BYTE_ALIGN_I is not 1; valid words are ignored.
    - When both are 1, go to HUNT and clear the good-word count and the prime flag.
  - HUNT:
    - Good word: good_cnt+1. Errored word: good_cnt=0.
    - good_cnt reaching C_LOCK_CNT: go to LOCKED, LOCK_O=1.
    - ERR_CNT and ERR_FLAG are not touched in HUNT.
  - LOCKED:
    - Errored word: ERR_FLAG_O pulses, ERR_CNT+1 (saturates at all-ones, no wrap), bad_cnt+1.
    - Good word: bad_cnt=0.
    - bad_cnt reaching C_UNLOCK_CNT: go to HUNT, LOCK_O=0, good_cnt=0.
    - The previous-word register keeps updating across this transition; no re-prime.
  - Any state: BIT_ALIGN_I or BYTE_ALIGN_I low → next cycle WAIT_ALIGN, LOCK_O=0, in-flight compare discarded. ERR_CNT is retained.
- DATA_VALID_I=0: pipeline holds; no counts or flags change.
- CLR_I and an error in the same cycle: clear wins, ERR_CNT=0, ERR_FLAG_O still pulses.
- CLKDIV_RST_I overrides CLR_I and all other inputs.

Decomposition:
- Package lvds_pkg holds:
  - FSM state encoding: WAIT_ALIGN=2'd0, HUNT=2'd1, LOCKED=2'd2.
  - PRBS7 tap constants (7, 6).
  - A function prbs7_expect(prev_word, cur_word, W).
- One sub-module, lvds_prbs_chk_lane: single-lane prime, compare, FSM and counters. The top instantiates it C_LANE_NUM times via generate and does the bus slicing.

Test Plan:
- Reset, aligns high, bench PRBS7 generator seeded 7'h7F, continuous valid → LOCK_O=2'b11 exactly C_LOCK_CNT+1 valid words (incl. prime) + 2 cycles after first word; ERR_CNT_O=0.
- Locked, single bit flip in lane 0 word → ERR_CNT lane0 increments by 1 or 2, ERR_FLAG_O pulses the same number of cycles, LOCK_O stays 2'b11, lane 1 unaffected.
- Lane 1 fed constant 8'h00 → LOCK_O[1] never asserts over 1000 words; LOCK_O[0] locks normally.
- Locked, lane 0 fed 4 consecutive random non-PRBS words → LOCK_O[0]=0 after the 4th errored result; ERR_CNT lane0=4. PRBS resumes → relock after C_LOCK_CNT good words.
- Locked, drop BYTE_ALIGN_I[1] one cycle → LOCK_O[1]=0 next cycle, ERR_CNT lane1 retained. Realign → prime then relock. Pulse CLR_I together with an error → ERR_CNT=0.
- Force the error counter near saturation (C_ERR_CNT_W=4, 20 errored words) → ERR_CNT_O holds 4'hF, no wrap. Assert CLKDIV_RST_I mid-lock → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/lvds_pkg.sv
// Shared types and the PRBS7 predictor used by the per-lane LVDS PRBS checker.
package lvds_pkg;

    typedef enum logic [1:0] {
        StWaitAlign = 2'd0,
        StHunt      = 2'd1,
        StLocked    = 2'd2
    } lane_state_e;

    // x^7 + x^6 + 1: s[t] = s[t-6] ^ s[t-7]
    localparam int unsigned PrbsTapA = 7;
    localparam int unsigned PrbsTapB = 6;
    localparam int unsigned MaxWordW = 16;

    // Bit w-1 of a word is earliest on the wire, so {prev, cur} reads oldest-first from the MSB.
    // Each predicted bit of cur uses the received history, which makes the checker self-syncing.
    function automatic logic [MaxWordW-1:0] prbs7_expect(input logic [MaxWordW-1:0] prev_word,
                                                         input logic [MaxWordW-1:0] cur_word,
                                                         input int unsigned w);
        logic [2*MaxWordW-1:0] hist;
        logic [MaxWordW-1:0]   exp_word;
        logic [4:0]            idx_a;
        logic [4:0]            idx_b;
        logic [3:0]            idx_j;
        hist     = ({{MaxWordW{1'b0}}, prev_word} << w) | {{MaxWordW{1'b0}}, cur_word};
        exp_word = '0;
        for (int unsigned j = 0; j < MaxWordW; j++) begin
            if (j < w) begin
                idx_a           = 5'(j + PrbsTapA);
                idx_b           = 5'(j + PrbsTapB);
                idx_j           = 4'(j);
                exp_word[idx_j] = hist[idx_a] ^ hist[idx_b];
            end
        end
        return exp_word;
    endfunction

endpackage

// File: rtl/lvds_prbs_chk_lane.sv
// Single-lane PRBS7 checker: input register, prime, compare, lock FSM and error counter.
module lvds_prbs_chk_lane
    import lvds_pkg::*;
#(
    parameter int unsigned DataW     = 8,
    parameter int unsigned LockCnt   = 64,
    parameter int unsigned UnlockCnt = 4,
    parameter int unsigned ErrCntW   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [DataW-1:0]   word_i,
    input  logic               valid_i,
    input  logic               align_i,
    input  logic               clr_i,
    output logic               lock_o,
    output logic               err_flag_o,
    output logic [ErrCntW-1:0] err_cnt_o
);

    localparam int unsigned GoodW = $clog2(LockCnt + 1);
    localparam int unsigned BadW  = $clog2(UnlockCnt + 1);

    lane_state_e        state_q, state_d;
    logic [DataW-1:0]   word_q, word_d;
    logic [DataW-1:0]   prev_q, prev_d;
    logic               valid_q, valid_d;
    logic               primed_q, primed_d;
    logic [GoodW-1:0]   good_cnt_q, good_cnt_d;
    logic [BadW-1:0]    bad_cnt_q, bad_cnt_d;
    logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;
    logic               err_flag_q, err_flag_d;
    logic [DataW-1:0]   exp_word;
    logic               word_good;

    // All-zero is the PRBS lock-up state, so it is never accepted as good.
    always_comb begin
        exp_word  = DataW'(prbs7_expect(MaxWordW'(prev_q), MaxWordW'(word_q), DataW));
        word_good = (word_q == exp_word) && (word_q != '0);
    end

    always_comb begin
        valid_d = valid_i & align_i;
        word_d  = valid_d ? word_i : word_q;
    end

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        primed_d   = primed_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_flag_d = 1'b0;
        if (!align_i) begin
            state_d = StWaitAlign;
        end else begin
            case (state_q)
                StWaitAlign: begin
                    state_d    = StHunt;
                    good_cnt_d = '0;
                    primed_d   = 1'b0;
                end
                StHunt, StLocked: begin
                    if (valid_q) begin
                        prev_d = word_q;
                        if (!primed_q) begin
                            primed_d = 1'b1;
                        end else if (state_q == StHunt) begin
                            if (word_good) begin
                                good_cnt_d = good_cnt_q + 1'b1;
                                if (good_cnt_q == GoodW'(LockCnt - 1)) begin
                                    state_d   = StLocked;
                                    bad_cnt_d = '0;
                                end
                            end else begin
                                good_cnt_d = '0;
                            end
                        end else if (word_good) begin
                            bad_cnt_d = '0;
                        end else begin
                            err_flag_d = 1'b1;
                            bad_cnt_d  = bad_cnt_q + 1'b1;
                            if (err_cnt_q != '1) begin
                                err_cnt_d = err_cnt_q + 1'b1;
                            end
                            if (bad_cnt_q == BadW'(UnlockCnt - 1)) begin
                                state_d    = StHunt;
                                good_cnt_d = '0;
                            end
                        end
                    end
                end
                default: state_d = StWaitAlign;
            endcase
        end
        if (clr_i) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StWaitAlign;
            word_q     <= '0;
            prev_q     <= '0;
            valid_q    <= 1'b0;
            primed_q   <= 1'b0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            prev_q     <= prev_d;
            valid_q    <= valid_d;
            primed_q   <= primed_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign lock_o     = (state_q == StLocked);
    assign err_flag_o = err_flag_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: rtl/lvds_prbs_chk.sv
// Multi-lane PRBS7 checker for LVDS link bring-up; one independent checker per lane.
module lvds_prbs_chk #(
    parameter int unsigned C_LANE_NUM            = 2,
    parameter int unsigned C_DATA_WIDTH_PER_LANE = 8,
    parameter int unsigned C_LOCK_CNT            = 64,
    parameter int unsigned C_UNLOCK_CNT          = 4,
    parameter int unsigned C_ERR_CNT_W           = 16
) (
    input  logic                                          CLKDIV_I,
    input  logic                                          CLKDIV_RST_I,
    input  logic [C_LANE_NUM*C_DATA_WIDTH_PER_LANE-1:0]   LVDS_DATA_I,
    input  logic                                          DATA_VALID_I,
    input  logic [C_LANE_NUM-1:0]                         BIT_ALIGN_I,
    input  logic [C_LANE_NUM-1:0]                         BYTE_ALIGN_I,
    input  logic                                          CLR_I,
    output logic [C_LANE_NUM-1:0]                         LOCK_O,
    output logic [C_LANE_NUM-1:0]                         ERR_FLAG_O,
    output logic [C_LANE_NUM*C_ERR_CNT_W-1:0]             ERR_CNT_O
);

    for (genvar i = 0; i < C_LANE_NUM; i++) begin : g_lane
        lvds_prbs_chk_lane #(
            .DataW     (C_DATA_WIDTH_PER_LANE),
            .LockCnt   (C_LOCK_CNT),
            .UnlockCnt (C_UNLOCK_CNT),
            .ErrCntW   (C_ERR_CNT_W)
        ) u_lane (
            .clk_i      (CLKDIV_I),
            .rst_i      (CLKDIV_RST_I),
            .word_i     (LVDS_DATA_I[i*C_DATA_WIDTH_PER_LANE +: C_DATA_WIDTH_PER_LANE]),
            .valid_i    (DATA_VALID_I),
            .align_i    (BIT_ALIGN_I[i] & BYTE_ALIGN_I[i]),
            .clr_i      (CLR_I),
            .lock_o     (LOCK_O[i]),
            .err_flag_o (ERR_FLAG_O[i]),
            .err_cnt_o  (ERR_CNT_O[i*C_ERR_CNT_W +: C_ERR_CNT_W])
        );
    end

endmodule
